// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with target buffer and EX-stage
// misprediction detection; trains one edge after a branch resolves.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] miss_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  fetch_hit;
    logic                  ex_hit;
    logic                  ex_br;

    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag = fetch_pc[31:INDEX_BITS+2];
    assign ex_idx    = ex_pc[INDEX_BITS+1:2];
    assign ex_tag    = ex_pc[31:INDEX_BITS+2];
    assign ex_br     = ex_valid && ex_is_branch;

    // Fetch reads registered state only, so a same-cycle train is not visible.
    always_comb begin
        fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
        pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
    end

    always_comb begin
        ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        mispredict  = ex_br && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_pred_target != ex_target)));
        redirect_pc = (ex_br && ex_taken) ? ex_target : ex_pc + 32'd4;
    end

    // tag/target need no reset: they are ignored while the entry is invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            branch_count <= '0;
            miss_count   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'd1;
            end
        end else if (ex_br) begin
            branch_count <= branch_count + 32'd1;
            if (mispredict) begin
                miss_count <= miss_count + 32'd1;
            end
            if (ex_hit) begin
                if (ex_taken) begin
                    target_q[ex_idx] <= ex_target;
                    if (ctr_q[ex_idx] != 2'd3) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    end
                end else if (ctr_q[ex_idx] != 2'd0) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; stimulus pushes hand-computed
// expectations to a queue that a negedge monitor pops and compares.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic        full;
        logic        pt;
        logic [31:0] ptgt;
        logic        misp;
        logic [31:0] redir;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL step%0d %s actual=%h expected=%h", id, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.full) begin
                chk(e.id, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
                chk(e.id, "pred_target", pred_target, e.ptgt);
                chk(e.id, "mispredict", {31'd0, mispredict}, {31'd0, e.misp});
                chk(e.id, "redirect_pc", redirect_pc, e.redir);
            end
            chk(e.id, "branch_count", branch_count, e.bc);
            chk(e.id, "miss_count", miss_count, e.mc);
        end
    end

    int step_id = 0;

    // Drive one cycle of inputs just after the edge and queue what the
    // outputs must be before the next edge.
    task automatic step(input logic r, input logic [31:0] fpc,
                        input logic v, input logic br, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt,
                        input logic ppt, input logic [31:0] pptg,
                        input logic full, input logic e_pt, input logic [31:0] e_ptgt,
                        input logic e_m, input logic [31:0] e_r,
                        input logic [31:0] e_bc, input logic [31:0] e_mc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; fetch_pc = fpc; ex_valid = v; ex_is_branch = br; ex_pc = pc;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ppt; ex_pred_target = pptg;
        e.id = step_id; e.full = full; e.pt = e_pt; e.ptgt = e_ptgt;
        e.misp = e_m; e.redir = e_r; e.bc = e_bc; e.mc = e_mc;
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic idle(input logic [31:0] fpc, input logic e_pt, input logic [31:0] e_ptgt,
                        input logic [31:0] e_bc, input logic [31:0] e_mc);
        step(1'b0, fpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             1'b1, e_pt, e_ptgt, 1'b0, 32'h4, e_bc, e_mc);
    endtask

    initial begin
        rst = 1'b1; fetch_pc = '0; ex_valid = 0; ex_is_branch = 0; ex_pc = '0;
        ex_taken = 0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
        repeat (2) @(posedge clk);

        //    r fetch         v br pc            tk tgt          ppt pptg         f pt ptgt         m redir        bc  mc
        idle(32'h100, 0, 32'h104, 0, 0);
        step(0, 32'h100,      1, 1, 32'h100,     1, 32'h40,      0, 32'h104,      1, 0, 32'h104,    1, 32'h40,     0, 0);
        idle(32'h100, 1, 32'h40, 1, 1);
        step(0, 32'h100,      1, 1, 32'h100,     0, 32'h40,      1, 32'h40,       1, 1, 32'h40,     1, 32'h104,    1, 1);
        step(0, 32'h100,      1, 1, 32'h100,     0, 32'h40,      0, 32'h104,      1, 0, 32'h104,    0, 32'h104,    2, 2);
        idle(32'h100, 0, 32'h104, 3, 2);
        // ctr is 0: a further not-taken must saturate, not wrap
        step(0, 32'h100,      1, 1, 32'h100,     0, 32'h40,      0, 32'h104,      1, 0, 32'h104,    0, 32'h104,    3, 2);
        step(0, 32'h100,      1, 1, 32'h100,     1, 32'h40,      0, 32'h104,      1, 0, 32'h104,    1, 32'h40,     4, 2);
        idle(32'h100, 0, 32'h104, 5, 3);
        step(0, 32'h100,      1, 1, 32'h100,     1, 32'h40,      0, 32'h104,      1, 0, 32'h104,    1, 32'h40,     5, 3);
        step(0, 32'h100,      1, 1, 32'h100,     1, 32'h40,      1, 32'h40,       1, 1, 32'h40,     0, 32'h40,     6, 4);
        // ctr is 3: a further taken must saturate
        step(0, 32'h100,      1, 1, 32'h100,     1, 32'h40,      1, 32'h40,       1, 1, 32'h40,     0, 32'h40,     7, 4);
        step(0, 32'h100,      1, 1, 32'h100,     0, 32'h40,      1, 32'h40,       1, 1, 32'h40,     1, 32'h104,    8, 4);
        idle(32'h100, 1, 32'h40, 9, 5);
        // indirect target change on a predicted-taken branch
        step(0, 32'h100,      1, 1, 32'h100,     1, 32'h300,     1, 32'h200,      1, 1, 32'h40,     1, 32'h300,    9, 5);
        idle(32'h100, 1, 32'h300, 10, 6);
        // alias 0x200 shares index 0, replaces the 0x100 entry
        step(0, 32'h100,      1, 1, 32'h200,     1, 32'h80,      0, 32'h204,      1, 1, 32'h300,    1, 32'h80,     10, 6);
        idle(32'h100, 0, 32'h104, 11, 7);
        idle(32'h200, 1, 32'h80, 11, 7);
        // tag miss, not taken: table untouched
        step(0, 32'h200,      1, 1, 32'h100,     0, 32'h40,      0, 32'h104,      1, 1, 32'h80,     0, 32'h104,    11, 7);
        idle(32'h200, 1, 32'h80, 12, 7);
        // qualifiers: non-valid or non-branch must not resolve or train
        step(0, 32'h300,      0, 1, 32'h300,     1, 32'h500,     0, 32'h304,      1, 0, 32'h304,    0, 32'h304,    12, 7);
        step(0, 32'h300,      1, 0, 32'h300,     1, 32'h500,     0, 32'h304,      1, 0, 32'h304,    0, 32'h304,    12, 7);
        idle(32'h300, 0, 32'h304, 12, 7);
        // 32-bit wrap of +4
        step(0, 32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC, 0, 32'h0,      0, 32'h0,        1, 0, 32'h0,      0, 32'h0,      12, 7);
        // reset with a resolving branch: reset wins, nothing recorded
        step(1, 32'h200,      1, 1, 32'h200,     1, 32'h900,     0, 32'h204,      0, 0, 32'h0,      0, 32'h0,      13, 7);
        idle(32'h200, 0, 32'h204, 0, 0);
        idle(32'h100, 0, 32'h104, 0, 0);

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
